// File: rtl/gpr_wb_scheduler_if.sv
// rtl/gpr_wb_scheduler_if.sv - writeback request handshakes and register-file write port
interface gpr_wb_scheduler_if #(
  parameter int XLEN = 64
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;

  logic            wr_en;
  logic [4:0]      rd_id;
  logic [XLEN-1:0] rd;

  // Requester/consumer side
  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    input  wr_en, rd_id, rd
  );

  // Scheduler side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    output wr_en, rd_id, rd
  );
endinterface

// File: rtl/gpr_wb_scheduler.sv
// rtl/gpr_wb_scheduler.sv - register-file write port arbiter with pending-write scoreboard
module gpr_wb_scheduler #(
  parameter int XLEN       = 64,
  parameter int MAX_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  gpr_wb_scheduler_if.slave       wb,
  input  logic                    issue_en,
  input  logic [4:0]              issue_rd,
  input  logic [4:0]              r1_id,
  input  logic [4:0]              r2_id,
  output logic                    r1_busy,
  output logic                    r2_busy,
  output logic [31:0]             pending
);

  localparam logic [3:0] MAX_S = 4'(MAX_STREAK);

  logic [3:0]  streak;
  logic        alu_grant;
  logic        ld_grant;
  logic        contested;
  logic [31:0] pending_nxt;

  // Arbitration: load normally wins a contest; ALU wins once the load streak saturates.
  always_comb begin
    alu_grant    = 1'b0;
    ld_grant     = 1'b0;
    contested    = wb.alu_valid & wb.ld_valid;
    if (!rst) begin
      if (contested) begin
        alu_grant = (streak == MAX_S);
        ld_grant  = (streak != MAX_S);
      end else begin
        alu_grant = wb.alu_valid;
        ld_grant  = wb.ld_valid;
      end
    end
    wb.alu_ready = alu_grant;
    wb.ld_ready  = ld_grant;
  end

  // Streak of contested load wins; any ALU grant or idle ALU restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (!wb.alu_valid || alu_grant) begin
      streak <= '0;
    end else if (ld_grant && contested && (streak != MAX_S)) begin
      streak <= streak + 4'd1;
    end
  end

  // Register the winning write; destination 0 is swallowed without a port write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb.wr_en <= 1'b0;
      wb.rd_id <= '0;
      wb.rd    <= '0;
    end else if (alu_grant && (wb.alu_rd != 5'd0)) begin
      wb.wr_en <= 1'b1;
      wb.rd_id <= wb.alu_rd;
      wb.rd    <= wb.alu_data;
    end else if (ld_grant && (wb.ld_rd != 5'd0)) begin
      wb.wr_en <= 1'b1;
      wb.rd_id <= wb.ld_rd;
      wb.rd    <= wb.ld_data;
    end else begin
      wb.wr_en <= 1'b0;
    end
  end

  // Scoreboard update: clear on retiring write, then set on issue so a newer writer stays pending.
  always_comb begin
    pending_nxt = pending;
    if (wb.wr_en) begin
      pending_nxt[wb.rd_id] = 1'b0;
    end
    if (issue_en && (issue_rd != 5'd0)) begin
      pending_nxt[issue_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Hazard lookup; the in-flight write is forwarded by the register file so it is not busy.
  always_comb begin
    r1_busy = pending[r1_id] & (r1_id != 5'd0) & ~(wb.wr_en & (wb.rd_id == r1_id));
    r2_busy = pending[r2_id] & (r2_id != 5'd0) & ~(wb.wr_en & (wb.rd_id == r2_id));
  end

endmodule

// File: doc/gpr_wb_scheduler.md
Name: gpr_wb_scheduler

Overview:
Shares the single write port of the 64-bit register file between two writeback requesters: the ALU result path and the load unit. Each requester uses a valid/ready handshake. The block registers the winning write onto the register-file write port. It also keeps a 32-entry pending-write scoreboard, which lets decode stall on read-after-write hazards against in-flight destinations.

Parameters:
XLEN, 64, data width of the writeback path and register file
MAX_STREAK, 4, number of consecutive contested load grants allowed before the ALU is forced a grant (range 1..15)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
issue_en  input  1  decode issues an instruction that will write issue_rd
issue_rd  input  5  destination register of the issued instruction
alu_valid  input  1  ALU writeback request
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
alu_ready  output  1  ALU request accepted this cycle
ld_valid  input  1  load-unit writeback request
ld_rd  input  5  load destination register
ld_data  input  XLEN  load result
ld_ready  output  1  load request accepted this cycle
wr_en  output  1  register-file write enable
rd_id  output  5  register-file write index
rd  output  XLEN  register-file write data
r1_id  input  5  decode source register 1
r2_id  input  5  decode source register 2
r1_busy  output  1  source 1 has an unresolved pending write
r2_busy  output  1  source 2 has an unresolved pending write
pending  output  32  scoreboard bit vector; bit 0 is always 0

Behaviour:
- Reset, asynchronous: wr_en=0, rd_id=0, rd=0, pending=0, streak counter=0. alu_ready, ld_ready, r1_busy and r2_busy are combinational and therefore read 0 while rst is high.
- Grant, combinational, one grant at most per cycle:
  - Only one requester valid: that requester is ready.
  - Both valid: the load wins, unless streak==MAX_STREAK, in which case the ALU wins.
  - Neither valid: both ready signals are 0.
- Streak counter:
  - Increments on a contested cycle where the load is granted.
  - Clears when the ALU is granted or when alu_valid=0.
  - Saturates at MAX_STREAK.
- Transfer occurs when valid & ready are both high. The transfer is registered, giving 1-cycle latency to the port:
  - Next cycle, wr_en=1 and rd_id/rd take the winner's rd/data.
  - Otherwise wr_en=0, and rd_id/rd hold their last values.
- A transfer with destination 0 is accepted (ready=1), but wr_en stays 0 next cycle.
- Requesters hold valid/rd/data stable until ready. The block never drops or duplicates an accepted request.
- Scoreboard:
  - issue_en with issue_rd!=0 sets pending[issue_rd] at the clock edge.
  - The cycle wr_en=1 clears pending[rd_id] at the clock edge.
  - Set and clear on the same index in the same cycle: set wins, because the newer instruction is still outstanding.
  - Clears of registers that are not pending are harmless.
- Busy, combinational:
  - rN_busy = pending[rN_id] & (rN_id!=0) & ~(wr_en & rd_id==rN_id).
  - The register file forwards the in-flight write, so a register being written this cycle is not busy.
- Simultaneous issue_en and a read of the same index: busy reflects the pending value before the edge.
- Reset mid-transfer: the outstanding registered write is discarded (wr_en=0). Requesters must re-present after reset.

Test Plan:
- Reset with alu_valid=1, alu_rd=5, alu_data=0xAA -> while rst=1: wr_en=0, alu_ready=0, pending=0. First cycle after release: alu_ready=1. Next cycle: wr_en=1, rd_id=5, rd=0xAA.
- ld_valid=1 (rd 7, 0x11) and alu_valid=1 (rd 8, 0x22) held, MAX_STREAK=4, the load re-presenting new data each grant -> ld_ready for 4 cycles, then alu_ready on cycle 5. The ALU write (rd_id=8, rd=0x22) appears on cycle 6.
- issue_en rd=3, then r1_id=3 -> r1_busy=1. ALU writeback to 3 -> in the wr_en cycle r1_busy=0, next cycle pending[3]=0.
- issue_en rd=9 in the same cycle as wr_en with rd_id=9 -> pending[9]=1 afterwards, so r2_busy=1 with r2_id=9.
- alu_valid=1, alu_rd=0, data=0xFF -> alu_ready=1, wr_en stays 0. issue_en rd=0 leaves pending=0. r1_id=0 gives r1_busy=0.
- Assert rst one cycle after an accepted load (rd 4) -> wr_en never asserts for rd 4, and pending clears to 0.
